// File: rtl/dfr_pkg.sv
// Shared constants and helpers for the RAM port arbiter and its requesters.
package dfr_pkg;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned REQ_HOST = 0;
    localparam int unsigned REQ_RES  = 1;
    localparam int unsigned REQ_MM   = 2;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Requester index reached by stepping 'off' places forward from 'base', wrapping at NUM_REQ.
    function automatic logic [1:0] req_wrap(input logic [1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return 2'(sum % NUM_REQ);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Cyclic first-set search: returns the first asserted request at or after ptr.
module rr_priority_picker
    import dfr_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    assign valid = |req;

    // Scan from the farthest candidate back to ptr so the nearest set request wins.
    always_comb begin
        idx  = 2'd0;
        cand = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = req_wrap(ptr, unsigned'(k));
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Three-requester arbiter in front of a single-port synchronous RAM.
// Round-robin with optional host priority, bounded bursts while others wait.
module ram_port_arbiter
    import dfr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_prio,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            wen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          ram_wen,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic                          arb_busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e             state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;

    logic                   pick_valid;
    logic [1:0]             pick_idx;
    logic                   beat;
    logic                   others_req;
    logic [CNT_W-1:0]       cnt_inc;
    logic [NUM_REQ-1:0]     owner_mask;
    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  din_arr  [NUM_REQ];

    rr_priority_picker u_picker (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Unpack per-requester address and write-data slices.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            din_arr[i]  = din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign beat       = (state_q == StGrant) && req[owner_q];
    assign owner_mask = 3'b001 << owner_q;
    assign others_req = |(req & ~owner_mask);
    assign cnt_inc    = beat_cnt_q + 1'b1;

    // State register: FSM, owner, round-robin pointer, burst counter, read-valid pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 2'(REQ_HOST);
            rr_ptr_q   <= 2'd0;
            beat_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and decide on release in GRANT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        rvalid_d   = '0;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d    = StGrant;
                    owner_d    = (host_prio && req[REQ_HOST]) ? 2'(REQ_HOST) : pick_idx;
                    beat_cnt_d = '0;
                end
            end
            StGrant: begin
                if (!beat) begin
                    state_d  = StIdle;
                    rr_ptr_d = req_wrap(owner_q, 1);
                end else begin
                    rvalid_d[owner_q] = ~wen[owner_q];
                    if (cnt_inc == CNT_W'(MAX_BURST)) begin
                        // Burst limit only forces a handover when someone else is waiting.
                        beat_cnt_d = '0;
                        if (others_req) begin
                            state_d  = StIdle;
                            rr_ptr_d = req_wrap(owner_q, 1);
                        end
                    end else begin
                        beat_cnt_d = cnt_inc;
                    end
                end
            end
        endcase
    end

    // Outputs: steer the owner's controls to the RAM only during a beat.
    always_comb begin
        gnt      = '0;
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (beat) begin
            gnt[owner_q] = 1'b1;
            ram_wen      = wen[owner_q];
            ram_addr     = addr_arr[owner_q];
            ram_din      = din_arr[owner_q];
        end
    end

    assign arb_busy = (state_q == StGrant);
    assign rvalid   = rvalid_q;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model with its own memory image.
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk;
    logic            rst;
    logic            host_prio;
    logic [2:0]      req;
    logic [2:0]      wen;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] din;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            ram_wen;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;
    logic            arb_busy;

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .host_prio (host_prio),
        .req       (req),
        .wen       (wen),
        .addr      (addr),
        .din       (din),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency, with a preload port for the bench.
    bit [DW-1:0] mem [65536];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state: owner -1 means idle.
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    logic [2:0]  m_rv;
    logic [31:0] m_rdata;
    logic [31:0] mm [int];

    logic [2:0]  last_gnt;
    logic [2:0]  last_rv;
    logic [31:0] last_rdata;
    logic        last_wen;
    logic [15:0] last_addr;
    logic        last_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mm_rd(input int a);
        return mm.exists(a) ? mm[a] : 32'h0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_rv    = '0;
        m_rdata = '0;
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model.
    task automatic tick();
        logic [2:0]  e_gnt;
        logic        e_wen;
        logic [15:0] e_addr;
        logic [31:0] e_din;
        logic        e_busy;
        logic [2:0]  e_rv;
        logic        bt;
        int          o;
        @(negedge clk);
        e_gnt = '0; e_wen = 1'b0; e_addr = '0; e_din = '0; e_busy = 1'b0; bt = 1'b0;
        o = m_owner;
        if (!rst && o >= 0) begin
            e_busy = 1'b1;
            bt = req[o];
            if (bt) begin
                e_gnt  = 3'(1 << o);
                e_wen  = wen[o];
                e_addr = addr[o*AW +: AW];
                e_din  = din[o*DW +: DW];
            end
        end
        e_rv = rst ? 3'b000 : m_rv;
        check("gnt", 64'(gnt), 64'(e_gnt));
        check("gnt_onehot", 64'($countones(gnt) <= 1), 64'(1));
        check("ram_wen", 64'(ram_wen), 64'(e_wen));
        check("ram_addr", 64'(ram_addr), 64'(e_addr));
        check("ram_din", 64'(ram_din), 64'(e_din));
        check("arb_busy", 64'(arb_busy), 64'(e_busy));
        check("rvalid", 64'(rvalid), 64'(e_rv));
        if (e_rv != 3'b000) check("rdata", 64'(rdata), 64'(m_rdata));
        last_gnt = gnt; last_rv = rvalid; last_rdata = rdata;
        last_wen = ram_wen; last_addr = ram_addr; last_busy = arb_busy;

        if (rst) begin
            model_reset();
        end else begin
            m_rv = '0;
            if (o < 0) begin
                if (req != 3'b000) begin
                    if (host_prio && req[0]) m_owner = 0;
                    else begin
                        for (int k = 0; k < 3; k++) begin
                            if (req[(m_ptr + k) % 3]) begin
                                m_owner = (m_ptr + k) % 3;
                                break;
                            end
                        end
                    end
                    m_cnt = 0;
                end
            end else if (!bt) begin
                m_owner = -1;
                m_ptr   = (o + 1) % 3;
            end else begin
                if (e_wen) mm[int'(e_addr)] = e_din;
                else begin
                    m_rv[o] = 1'b1;
                    m_rdata = mm_rd(int'(e_addr));
                end
                m_cnt++;
                if (m_cnt == MB) begin
                    m_cnt = 0;
                    if ((req & ~3'(1 << o)) != 3'b000) begin
                        m_owner = -1;
                        m_ptr   = (o + 1) % 3;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [15:0] a, input logic [31:0] d);
        addr[i*AW +: AW] = a;
        din[i*DW +: DW]  = d;
    endtask

    initial begin
        rst = 1'b1; host_prio = 1'b0; req = '0; wen = '0; addr = '0; din = '0;
        pre_we = 1'b1; pre_addr = 16'h0005; pre_data = 32'hDEADBEEF;
        mm[5] = 32'hDEADBEEF;
        model_reset();
        tick();
        pre_we = 1'b0;
        tick();
        check("reset_gnt", 64'(last_gnt), 64'(0));
        check("reset_busy", 64'(last_busy), 64'(0));

        // Round-robin with all three requesting, starting from pointer 0.
        rst = 1'b0;
        req = 3'b111;
        for (int k = 0; k < 20; k++) begin
            logic [2:0] exp_g;
            tick();
            if (k == 0 || (k - 1) % 5 == 4) exp_g = 3'b000;
            else exp_g = 3'(1 << (((k - 1) / 5) % 3));
            check("rr_order", 64'(last_gnt), 64'(exp_g));
        end

        // Host priority with pointer now at 1.
        req = 3'b011; host_prio = 1'b1;
        tick();
        tick();
        check("host_prio_gnt", 64'(last_gnt), 64'(3'b001));
        req = 3'b000; host_prio = 1'b0;
        tick();

        // Solo burst never leaves GRANT.
        req = 3'b100;
        tick();
        for (int k = 1; k < 40; k++) begin
            tick();
            check("solo_gnt", 64'(last_gnt), 64'(3'b100));
        end
        req = 3'b000;
        tick();
        tick();

        // Single read of address 5 by requester 1.
        req = 3'b010; set_slot(1, 16'h0005, 32'h0);
        tick();
        check("rd_lat_gnt0", 64'(last_gnt), 64'(0));
        tick();
        check("rd_gnt", 64'(last_gnt), 64'(3'b010));
        check("rd_addr", 64'(last_addr), 64'(16'h0005));
        req = 3'b000;
        tick();
        check("rd_rvalid", 64'(last_rv), 64'(3'b010));
        check("rd_rdata", 64'(last_rdata), 64'(32'hDEADBEEF));

        // Reset right after a read beat discards the pending rvalid.
        req = 3'b010;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_rvalid", 64'(last_rv), 64'(0));
        check("rst_gnt", 64'(last_gnt), 64'(0));
        check("rst_wen", 64'(last_wen), 64'(0));
        check("rst_busy", 64'(last_busy), 64'(0));
        rst = 1'b0; req = 3'b000;
        tick();
        check("post_rst_busy", 64'(last_busy), 64'(0));

        // Host writes 0x00FF, matrix multiplier reads it back.
        req = 3'b001; wen = 3'b001; set_slot(0, 16'h00FF, 32'h12345678);
        tick();
        tick();
        check("wr_wen", 64'(last_wen), 64'(1));
        check("wr_addr", 64'(last_addr), 64'(16'h00FF));
        req = 3'b000; wen = 3'b000;
        tick();
        req = 3'b100; set_slot(2, 16'h00FF, 32'h0);
        tick();
        tick();
        req = 3'b000;
        tick();
        check("wr_rd_rvalid", 64'(last_rv), 64'(3'b100));
        check("wr_rd_rdata", 64'(last_rdata), 64'(32'h12345678));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                set_slot(i, 16'($urandom_range(0, 15)), $urandom);
            end
            host_prio = ($urandom_range(0, 3) == 0);
            wen = 3'($urandom);
            rst = (n == 300);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
